// File: rtl/adc_acq_sched.sv
// adc_acq_sched: periodic acquisition scheduler for adc_buff with a valid/ready byte readout.
// Build option ACQ_HEADER_EN prefixes every frame with 0xA5 and the low byte of frame_cnt.
module adc_acq_sched #(
    parameter int BUF_DEPTH = 256,
    parameter int RD_LAT    = 1,
    parameter int TIMEOUT   = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] period,
    input  logic [2:0]  rate_cfg,
    input  logic        clr_err,
    output logic        start_pulse,
    output logic [2:0]  rate,
    input  logic        write_done,
    output logic [7:0]  read_addr,
    input  logic [7:0]  dout,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic        overrun,
    output logic        timeout
);
    // state      | meaning
    // IDLE       | acquisition disabled
    // WAIT_TICK  | enabled, waiting for the period tick
    // START      | start_pulse high, rate latched
    // ACQ        | waiting for write_done, timeout counter running
    // HDR        | sending the two header bytes (ACQ_HEADER_EN only)
    // RD         | read_addr presented, waiting RD_LAT cycles for dout
    // SEND       | byte offered on tx, waiting for tx_ready
    // DONE       | frame counted, back to WAIT_TICK or IDLE
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_TICK, S_START, S_ACQ, S_HDR, S_RD, S_SEND, S_DONE
    } state_t;

    localparam int               TMO_W     = $clog2(TIMEOUT + 1);
    localparam logic [7:0]       LAST_ADDR = 8'(BUF_DEPTH - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(TIMEOUT - 1);
    localparam logic [1:0]       LAT_LOAD  = 2'(RD_LAT - 1);

    state_t            state;
    logic [15:0]       tick_cnt;
    logic [15:0]       tick_max;
    logic              tick;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [1:0]        lat_cnt;
`ifdef ACQ_HEADER_EN
    logic              hdr_sel;
`endif

    // period 0 behaves as period 1, so tick_max saturates at 0
    assign tick_max = (period == 16'd0) ? 16'd0 : period - 16'd1;
    assign tick     = enable && (tick_cnt >= tick_max);

    always_ff @(posedge clk) begin
        if (!reset || !enable || tick) tick_cnt <= '0;
        else                           tick_cnt <= tick_cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            start_pulse <= 1'b0;
            rate        <= '0;
            read_addr   <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            frame_cnt   <= '0;
            overrun     <= 1'b0;
            timeout     <= 1'b0;
            tmo_cnt     <= '0;
            lat_cnt     <= '0;
`ifdef ACQ_HEADER_EN
            hdr_sel     <= 1'b0;
`endif
        end else begin
            start_pulse <= 1'b0;
            // a new error in the same cycle as clr_err keeps the flag set
            if (tick && busy) overrun <= 1'b1;
            else if (clr_err) overrun <= 1'b0;
            if (clr_err)      timeout <= 1'b0;

            unique case (state)
                S_IDLE: if (enable) state <= S_WAIT_TICK;
                S_WAIT_TICK: begin
                    if (!enable) state <= S_IDLE;
                    else if (tick) begin
                        state       <= S_START;
                        start_pulse <= 1'b1;
                        rate        <= rate_cfg;
                        busy        <= 1'b1;
                    end
                end
                S_START: begin
                    state   <= S_ACQ;
                    tmo_cnt <= TMO_LOAD;
                end
                S_ACQ: begin
                    if (write_done) begin
`ifdef ACQ_HEADER_EN
                        state    <= S_HDR;
                        tx_data  <= 8'hA5;
                        tx_valid <= 1'b1;
                        hdr_sel  <= 1'b0;
`else
                        state     <= S_RD;
                        read_addr <= '0;
                        lat_cnt   <= LAT_LOAD;
`endif
                    end else if (tmo_cnt == '0) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_WAIT_TICK;
                    end else begin
                        tmo_cnt <= tmo_cnt - TMO_W'(1);
                    end
                end
`ifdef ACQ_HEADER_EN
                S_HDR: begin
                    if (tx_ready) begin
                        if (!hdr_sel) begin
                            tx_data <= frame_cnt[7:0];
                            hdr_sel <= 1'b1;
                        end else begin
                            tx_valid  <= 1'b0;
                            read_addr <= '0;
                            lat_cnt   <= LAT_LOAD;
                            state     <= S_RD;
                        end
                    end
                end
`endif
                S_RD: begin
                    if (lat_cnt == 2'd0) begin
                        tx_data  <= dout;
                        tx_valid <= 1'b1;
                        state    <= S_SEND;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                S_SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (read_addr == LAST_ADDR) begin
                            state <= S_DONE;
                        end else begin
                            read_addr <= read_addr + 8'd1;
                            lat_cnt   <= LAT_LOAD;
                            state     <= S_RD;
                        end
                    end
                end
                S_DONE: begin
                    frame_cnt <= frame_cnt + 16'd1;
                    busy      <= 1'b0;
                    state     <= enable ? S_WAIT_TICK : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_acq_sched.sv
// tb_adc_acq_sched: table of single-frame scenarios, hand-written corner sequences and a
// randomized multi-frame run scored against a frame-level model of the byte stream.
`timescale 1ns/1ps
module tb_adc_acq_sched;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;
    localparam int TMO   = 20;

    logic        clk = 1'b0;
    logic        reset, enable, clr_err, write_done, tx_ready;
    logic        start_pulse, tx_valid, busy, overrun, timeout;
    logic [15:0] period, frame_cnt;
    logic [2:0]  rate_cfg, rate;
    logic [7:0]  read_addr, dout, tx_data;

    logic [7:0]  mem [DEPTH];
    logic [7:0]  rd_pipe;
    logic [7:0]  exp_q [$];
    int          tests = 0, fails = 0, n_start = 0, cyc = 0, m_frames = 0, stall = 0;
    logic        rand_rdy = 1'b0, man_rdy = 1'b1;
    logic        prev_v = 1'b0, prev_r = 1'b0;
    logic [7:0]  prev_d = '0;

    typedef struct {
        int         per;
        int         k;
        logic [2:0] rcfg;
        int         lat;
        logic       tmo;
        logic       ovr;
        int         frames;
    } vec_t;
    vec_t vec [6];

    always #5 clk = ~clk;

    // adc_buff read port with two cycles of latency
    always @(posedge clk) rd_pipe <= read_addr;
    assign dout = mem[rd_pipe[1:0]];

    adc_acq_sched #(.BUF_DEPTH(DEPTH), .RD_LAT(LAT), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .enable(enable), .period(period), .rate_cfg(rate_cfg),
        .clr_err(clr_err), .start_pulse(start_pulse), .rate(rate), .write_done(write_done),
        .read_addr(read_addr), .dout(dout), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .frame_cnt(frame_cnt), .overrun(overrun),
        .timeout(timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // one clock: drive tx_ready, then score the byte the DUT accepts at the next edge
    task automatic step();
        @(negedge clk);
        cyc++;
        if (rand_rdy) begin
            tx_ready = (stall >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            stall    = tx_ready ? 0 : stall + 1;
        end else begin
            tx_ready = man_rdy;
        end
        if (start_pulse) n_start++;
        if (reset && prev_v && !prev_r)
            chk("valid_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_d});
        if (reset && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL tx_byte: got 0x%0h, expected no byte", tx_data);
            end else begin
                chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_v = tx_valid; prev_r = tx_ready; prev_d = tx_data;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0; enable = 1'b0; clr_err = 1'b0; write_done = 1'b0;
        man_rdy = 1'b1; rand_rdy = 1'b0;
        repeat (n) step();
        reset = 1'b1;
        exp_q.delete();
        m_frames = 0;
    endtask

    task automatic wait_start(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            step();
            if (start_pulse) ok = 1'b1;
        end
        tests++;
        if (!ok) begin fails++; $display("FAIL start_wait: no start_pulse in %0d cycles", max); end
    endtask

    task automatic wait_idle(input int max);
        bit ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            step();
            if (!busy) ok = 1'b1;
        end
        tests++;
        if (!ok) begin fails++; $display("FAIL idle_wait: busy still 1 after %0d cycles", max); end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            if (tx_valid) ok = 1'b1;
        end
        tests++;
        if (!ok) begin fails++; $display("FAIL valid_wait: tx_valid never rose"); end
    endtask

    // buffer responds k cycles after start_pulse; the frame counts only if k <= TIMEOUT
    task automatic frame_resp(input int k, input bit drop_en);
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
        repeat (k) step();
        if (k <= TMO) begin
`ifdef ACQ_HEADER_EN
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'(m_frames));
`endif
            for (int i = 0; i < DEPTH; i++) exp_q.push_back(mem[i]);
            m_frames++;
        end
        write_done = 1'b1;
        if (drop_en) enable = 1'b0;
        step();
        write_done = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit         ok;
        int         c0, s0, per, last, k;
        logic       m_tmo, bad;
        logic [2:0] exp_rate;
        logic [7:0] d0;

        vec[0] = '{per: 100, k: 3,  rcfg: 3'd1, lat: 100, tmo: 1'b0, ovr: 1'b0, frames: 1};
        vec[1] = '{per: 2,   k: 20, rcfg: 3'd6, lat: 2,   tmo: 1'b0, ovr: 1'b1, frames: 1};
        vec[2] = '{per: 60,  k: 21, rcfg: 3'd3, lat: 60,  tmo: 1'b1, ovr: 1'b0, frames: 0};
        vec[3] = '{per: 0,   k: 1,  rcfg: 3'd7, lat: 2,   tmo: 1'b0, ovr: 1'b1, frames: 1};
        vec[4] = '{per: 200, k: 20, rcfg: 3'd5, lat: 200, tmo: 1'b0, ovr: 1'b0, frames: 1};
        vec[5] = '{per: 1,   k: 21, rcfg: 3'd2, lat: 2,   tmo: 1'b1, ovr: 1'b1, frames: 0};

        period = 16'd10; rate_cfg = 3'd0; tx_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        do_reset(3);
        chk("reset_outs", {8'd0, start_pulse, rate, read_addr, tx_data, tx_valid, busy, overrun, timeout}, 32'd0);
        chk("reset_frame_cnt", {16'd0, frame_cnt}, 32'd0);

        // single-frame scenarios
        for (int v = 0; v < 6; v++) begin
            do_reset(2);
            period = 16'(vec[v].per); rate_cfg = vec[v].rcfg;
            c0 = cyc; s0 = n_start;
            enable = 1'b1;
            wait_start(400, ok);
            chk($sformatf("v%0d_start_latency", v), cyc - c0, vec[v].lat);
            chk($sformatf("v%0d_rate", v), {29'd0, rate}, {29'd0, vec[v].rcfg});
            frame_resp(vec[v].k, 1'b1);
            wait_idle(300);
            repeat (3) step();
            chk($sformatf("v%0d_frame_cnt", v), {16'd0, frame_cnt}, vec[v].frames);
            chk($sformatf("v%0d_timeout", v), {31'd0, timeout}, {31'd0, vec[v].tmo});
            chk($sformatf("v%0d_overrun", v), {31'd0, overrun}, {31'd0, vec[v].ovr});
            chk($sformatf("v%0d_starts", v), n_start - s0, 1);
            chk($sformatf("v%0d_bytes_left", v), exp_q.size(), 0);
            if (vec[v].tmo || vec[v].ovr) begin
                clr_err = 1'b1; step(); clr_err = 1'b0; step();
                chk($sformatf("v%0d_clr_err", v), {30'd0, overrun, timeout}, 32'd0);
            end
        end

        // tx_ready held low: byte and valid must stay put until accepted
        do_reset(2);
        period = 16'd50; man_rdy = 1'b0; enable = 1'b1;
        wait_start(100, ok);
        frame_resp(2, 1'b1);
        wait_valid(ok);
        d0 = tx_data;
        if (exp_q.size() > 0) chk("stall_first_byte", {24'd0, d0}, {24'd0, exp_q[0]});
        bad = 1'b0;
        repeat (10) begin
            step();
            if (tx_valid !== 1'b1 || tx_data !== d0) bad = 1'b1;
        end
        chk("stall_hold", {31'd0, bad}, 32'd0);
        man_rdy = 1'b1;
        wait_idle(100);
        chk("stall_frame_cnt", {16'd0, frame_cnt}, 32'd1);
        chk("stall_bytes_left", exp_q.size(), 0);

        // reset in the middle of SEND aborts the frame
        do_reset(2);
        period = 16'd30; man_rdy = 1'b0; enable = 1'b1;
        wait_start(100, ok);
        frame_resp(1, 1'b1);
        wait_valid(ok);
        reset = 1'b0;
        repeat (3) step();
        chk("midsend_reset_outs", {8'd0, start_pulse, rate, read_addr, tx_data, tx_valid, busy, overrun, timeout}, 32'd0);
        reset = 1'b1; exp_q.delete(); m_frames = 0; man_rdy = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            step();
            if (tx_valid || busy) bad = 1'b1;
        end
        chk("midsend_quiet", {31'd0, bad}, 32'd0);

        // short period: overrun, single start, clr_err losing to a concurrent tick
        do_reset(2);
        period = 16'd1; enable = 1'b1; s0 = n_start;
        wait_start(20, ok);
        frame_resp(3, 1'b0);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        chk("ovr_clr_tie", {30'd0, busy, overrun}, 32'd3);
        enable = 1'b0;
        wait_idle(100);
        chk("ovr_starts", n_start - s0, 1);
        chk("ovr_frame_cnt", {16'd0, frame_cnt}, 32'd1);
        chk("ovr_bytes_left", exp_q.size(), 0);
        clr_err = 1'b1; step(); clr_err = 1'b0; step();
        chk("ovr_cleared", {31'd0, overrun}, 32'd0);

        // randomized run: free-running period, random ready and write_done delays
        do_reset(2);
        per = $urandom_range(100, 200);
        period = 16'(per);
        rand_rdy = 1'b1;
        rate_cfg = 3'($urandom); exp_rate = rate_cfg;
        m_tmo = 1'b0; last = 0;
        enable = 1'b1;
        for (int f = 0; f < 10; f++) begin
            wait_start(2 * per + 20, ok);
            if (!ok) break;
            if (f > 0) chk("rnd_start_interval", cyc - last, per);
            last = cyc;
            chk("rnd_rate", {29'd0, rate}, {29'd0, exp_rate});
            rate_cfg = 3'($urandom); exp_rate = rate_cfg;
            k = $urandom_range(1, TMO + 3);
            if (k > TMO) m_tmo = 1'b1;
            frame_resp(k, 1'b0);
        end
        enable = 1'b0;
        wait_idle(200);
        repeat (3) step();
        chk("rnd_frame_cnt", {16'd0, frame_cnt}, m_frames);
        chk("rnd_timeout", {31'd0, timeout}, {31'd0, m_tmo});
        chk("rnd_overrun", {31'd0, overrun}, 32'd0);
        chk("rnd_bytes_left", exp_q.size(), 0);
        rand_rdy = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
